debug_data_receiver: RTL and testbench
======================================

// Module: debug_data_receiver
// PURPOSE
//  Deserialiser for the debug serial link: recovers WIDTH-bit words from the sclk/sdata/sframe lines
//  driven by the debug data sender. Sits on the host/bench side in a single system clock domain.
//  Oversamples the asynchronous link, samples sdata on sclk falling edges while sframe is high,
//  then presents each word on a valid/ack handshake.
// PARAMETERS
//  WIDTH        40  bits per frame; MSB is sent first
//  SYNC_STAGES  2   synchroniser flops on each of sclk/sdata/sframe (>=2)
// PORTS
//  clk        in   1      system clock; must be >= 8x the sclk frequency
//  rst_n      in   1      asynchronous, active-low reset
//  sclk       in   1      link bit clock (async); transmitter changes sdata on its rising edge
//  sdata      in   1      link serial data (async), MSB first
//  sframe     in   1      link frame strobe (async); high for exactly WIDTH sclk periods per word
//  data_out   out  WIDTH  received word, stable while data_valid=1
//  data_valid out  1      word available; held until data_ack
//  data_ack   in   1      consumer accepts word; effective only while data_valid=1
//  frame_err  out  1      one-clk pulse: frame length != WIDTH
//  overrun    out  1      one-clk pulse: word completed while data_valid=1; new word discarded
// BEHAVIOUR
//  Reset: all outputs=0, state=IDLE, shift register/bit counter=0, sync flops=0.
//  Sync: each input passes SYNC_STAGES flops plus one history flop for edge detection.
//   fall_s = sclk_prev & ~sclk_sync; rise_f/fall_f are derived the same way from sframe.
//  FSM:
//   IDLE  : rise_f (or sframe_sync=1) -> RECV, bit counter=0.
//   RECV  : fall_s -> shreg <= {shreg[WIDTH-2:0], sdata_sync}, count+1.
//           On the WIDTH-th sample -> WAIT. Next clk: word delivered (see Handshake).
//           fall_f with count<WIDTH -> frame_err pulse; shreg discarded; -> IDLE.
//   WAIT  : sframe_sync=0 -> IDLE. fall_s while sframe high -> frame_err pulse; stay in WAIT.
//  Simultaneous fall_f and fall_s in one clk: frame end wins; the sample is ignored.
//  Latency: data_valid rises within SYNC_STAGES+2 clk of the sclk falling edge that carries the last bit.
//  Handshake:
//   - Delivery with data_valid=0: data_out<=shreg, data_valid<=1.
//   - Delivery with data_valid=1: overrun pulse; data_out is unchanged.
//   - data_ack & data_valid -> data_valid<=0 next clk.
//   - Delivery and ack in the same clk: ack retires the old word, new word is loaded, data_valid stays 1,
//     no overrun.
//  Counter: ceil(log2(WIDTH+1)) bits; never wraps (RECV leaves at WIDTH).
//  Async reset mid-frame: everything returns to reset values. If sframe is already high after reset,
//   IDLE enters RECV on sframe_sync=1 and that partial frame ends in frame_err.
// TESTING
//  1 Reset, then send 40'hA9_9999_9991 (MSB first, 1 bit per 16 clk) -> data_valid=1,
//    data_out=40'hA999999991, frame_err=0.
//  2 Hold data_ack=0 and send 40'hA999999981, then 40'hE999999993
//    -> first word held; overrun pulses once; data_out stays 40'hA999999981.
//  3 Drop sframe after 25 bits -> frame_err pulses once, data_valid stays 0;
//    next full frame 40'h00000000FF is received correctly.
//  4 Frame held high for 41 sclk periods -> word delivered after bit 40, then one frame_err pulse in WAIT.
//  5 Assert rst_n=0 at bit 20, release, send a full frame 40'h123456789A
//    -> exactly one data_valid, data_out=40'h123456789A.
//  6 Pulse data_ack in the clk that a new word completes -> data_valid stays 1, overrun=0,
//    data_out=new word.

Source files
------------

// File: rtl/debug_data_receiver.sv
// Deserialiser for the debug serial link: oversamples sclk/sdata/sframe, shifts in one
// WIDTH-bit word per frame (MSB first) and presents it on a valid/ack handshake.
module debug_data_receiver #(
  parameter int unsigned WIDTH       = 40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             sframe,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StWait} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [WIDTH-1:0]       data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   deliver_q, deliver_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
  logic [SYNC_STAGES-1:0] sframe_sync_q, sframe_sync_d;
  logic                   sclk_prev_q, sframe_prev_q;

  logic sclk_s, sdata_s, sframe_s;
  logic fall_s, rise_f, fall_f, ack;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sdata_sync_d  = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
    sframe_sync_d = {sframe_sync_q[SYNC_STAGES-2:0], sframe};
    sclk_s        = sclk_sync_q[SYNC_STAGES-1];
    sdata_s       = sdata_sync_q[SYNC_STAGES-1];
    sframe_s      = sframe_sync_q[SYNC_STAGES-1];
    fall_s        = sclk_prev_q & ~sclk_s;
    rise_f        = ~sframe_prev_q & sframe_s;
    fall_f        = sframe_prev_q & ~sframe_s;
    ack           = data_ack & data_valid_q;
  end

  // State register plus datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shreg_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      deliver_q     <= 1'b0;
      sclk_sync_q   <= '0;
      sdata_sync_q  <= '0;
      sframe_sync_q <= '0;
      sclk_prev_q   <= 1'b0;
      sframe_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
      deliver_q     <= deliver_d;
      sclk_sync_q   <= sclk_sync_d;
      sdata_sync_q  <= sdata_sync_d;
      sframe_sync_q <= sframe_sync_d;
      sclk_prev_q   <= sclk_s;
      sframe_prev_q <= sframe_s;
    end
  end

  // Next-state logic. A frame end in the same clk as a bit sample wins; the sample is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (rise_f || sframe_s) begin
          state_d = StRecv;
          cnt_d   = '0;
        end
      end
      StRecv: begin
        if (fall_f) begin
          state_d = StIdle;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (fall_s) begin
          shreg_d = {shreg_q[WIDTH-2:0], sdata_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StWait;
        end
      end
      StWait: begin
        if (!sframe_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: error/delivery strobes and the valid/ack handshake.
  always_comb begin
    frame_err_d  = 1'b0;
    deliver_d    = 1'b0;
    overrun_d    = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    unique case (state_q)
      StRecv: begin
        if (fall_f) frame_err_d = 1'b1;
        else if (fall_s && cnt_q == LastCnt) deliver_d = 1'b1;
      end
      StWait: begin
        if (sframe_s && fall_s) frame_err_d = 1'b1;
      end
      default: ;
    endcase
    // An ack in the delivery clk retires the old word, so the new one is loaded without overrun.
    if (deliver_q) begin
      if (!data_valid_q || ack) begin
        data_out_d   = shreg_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ack) begin
      data_valid_d = 1'b0;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_debug_data_receiver.sv
// Bench for debug_data_receiver: directed frames, scoreboard queue of expected words,
// monitor pops and compares each newly presented word and counts error pulses.
module tb_debug_data_receiver;

  localparam int W = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sclk, sdata, sframe, data_ack;
  logic [W-1:0] data_out;
  logic         data_valid, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vrise_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  debug_data_receiver #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .sdata      (sdata),
    .sframe     (sframe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word is presented when data_valid rises or data_out changes while valid.
  initial begin
    logic         v_prev;
    logic [W-1:0] o_prev;
    logic [W-1:0] e;
    v_prev = 1'b0;
    o_prev = '0;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1 && (!v_prev || data_out !== o_prev)) begin
        checks++;
        if (!v_prev) vrise_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin
            errors++;
            $display("FAIL word: got %0h expected %0h", data_out, e);
          end
        end
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      v_prev = data_valid;
      o_prev = data_out;
    end
  end

  // Sends n bits of w MSB first (bits past W are 0), 16 clk per bit, sdata changing on sclk rise.
  // ack_last pulses data_ack in the clk the word is handed over; end_frame drops sframe after.
  task automatic send(input logic [W-1:0] w, input int n, input bit ack_last, input bit end_frame);
    @(negedge clk);
    sframe = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sclk  = 1'b1;
      sdata = (i < W) ? w[W-1-i] : 1'b0;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      if (ack_last && i == n - 1) begin
        repeat (3) @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
    end
    if (end_frame) begin
      sframe = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic ack_word();
    int i;
    for (i = 0; i < 100 && data_valid !== 1'b1; i++) @(negedge clk);
    chk("valid_before_ack", {63'd0, data_valid}, 64'd1);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    chk("valid_after_ack", {63'd0, data_valid}, 64'd0);
  endtask

  initial begin
    int vr;
    rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; sframe = 1'b0; data_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", {24'd0, data_out}, 64'd0);
    chk("rst_valid", {63'd0, data_valid}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single word
    exp_q.push_back(40'hA999999991);
    send(40'hA999999991, 40, 1'b0, 1'b1);
    chk("t1_valid", {63'd0, data_valid}, 64'd1);
    chk("t1_fe_cnt", fe_cnt, 0);
    ack_word();

    // 2: overrun while first word held
    exp_q.push_back(40'hA999999981);
    send(40'hA999999981, 40, 1'b0, 1'b1);
    send(40'hE999999993, 40, 1'b0, 1'b1);
    chk("t2_ov_cnt", ov_cnt, 1);
    chk("t2_data_out", {24'd0, data_out}, {24'd0, 40'hA999999981});
    chk("t2_valid", {63'd0, data_valid}, 64'd1);

    // 6: ack in the delivery clk while the old word is still held
    vr = vrise_cnt;
    exp_q.push_back(40'h5A3C96F00F);
    send(40'h5A3C96F00F, 40, 1'b1, 1'b1);
    chk("t6_valid", {63'd0, data_valid}, 64'd1);
    chk("t6_no_valid_drop", vrise_cnt, vr);
    chk("t6_ov_cnt", ov_cnt, 1);
    chk("t6_data_out", {24'd0, data_out}, {24'd0, 40'h5A3C96F00F});
    ack_word();

    // 3: short frame, then a good one
    send(40'hFFFF_0000_12, 25, 1'b0, 1'b1);
    chk("t3_fe_cnt", fe_cnt, 1);
    chk("t3_valid", {63'd0, data_valid}, 64'd0);
    exp_q.push_back(40'h00000000FF);
    send(40'h00000000FF, 40, 1'b0, 1'b1);
    ack_word();

    // 4: 41-bit frame
    exp_q.push_back(40'hC3C3C3C3C3);
    send(40'hC3C3C3C3C3, 41, 1'b0, 1'b1);
    chk("t4_fe_cnt", fe_cnt, 2);
    ack_word();

    // 5: reset at bit 20, then a full frame
    vr = vrise_cnt;
    send(40'hFEDCBA9876, 20, 1'b0, 1'b0);
    rst_n = 1'b0; sframe = 1'b0; sclk = 1'b0; sdata = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_valid", {63'd0, data_valid}, 64'd0);
    chk("t5_rst_data_out", {24'd0, data_out}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(40'h123456789A);
    send(40'h123456789A, 40, 1'b0, 1'b1);
    chk("t5_data_out", {24'd0, data_out}, {24'd0, 40'h123456789A});
    ack_word();
    repeat (20) @(negedge clk);
    chk("t5_one_valid", vrise_cnt - vr, 1);
    chk("t5_fe_cnt", fe_cnt, 2);
    chk("final_ov_cnt", ov_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
